// File: rtl/lf_share_ctrl.sv
// Four-channel loop filter sharing one accumulate/decay datapath.
// A round-robin grant in IDLE is followed by one CALC cycle that updates the granted channel.
module lf_share_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [3:0]          REQ,
    input  logic [4*DATA_W-1:0] C_IN,
    input  logic [3:0]          CLR,
    output logic [3:0]          ACK,
    output logic [ACC_W-1:0]    D_OUT,
    output logic [1:0]          D_CH,
    output logic                D_VLD,
    output logic                BUSY
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CALC  = 1'b1;
    localparam int         SHIFT = 4;

    logic [0:0]               state;
    logic [1:0]               last;
    logic [1:0]               g_p0;
    logic signed [DATA_W-1:0] c_p0;
    logic signed [ACC_W-1:0]  acc [4];
    logic signed [ACC_W-1:0]  e [4];
    logic                     req_any;
    logic [1:0]               gnt_idx;
    logic [1:0]               cand;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  e_nxt;

    // Sign-extend the phase error and apply the x2 input gain; sums wrap at ACC_W bits.
    function automatic logic signed [ACC_W-1:0] scale_in(input logic signed [DATA_W-1:0] c);
        return {{(ACC_W-DATA_W-1){c[DATA_W-1]}}, c, 1'b0};
    endfunction

    function automatic logic signed [ACC_W-1:0] decay(input logic signed [ACC_W-1:0] v);
        return {{SHIFT{v[ACC_W-1]}}, v[ACC_W-1:SHIFT]};
    endfunction

    always_comb begin
        req_any = 1'b0;
        gnt_idx = last;
        cand    = last;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!req_any && REQ[cand]) begin
                req_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        acc_nxt = scale_in(c_p0) + acc[g_p0] - e[g_p0];
        e_nxt   = decay(acc[g_p0]);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            last  <= 2'd3;
            ACK   <= '0;
            BUSY  <= 1'b0;
            D_VLD <= 1'b0;
            D_OUT <= '0;
            D_CH  <= '0;
        end else begin
            ACK   <= '0;
            D_VLD <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state <= CALC;
                        ACK   <= 4'b0001 << gnt_idx;
                        BUSY  <= 1'b1;
                        last  <= gnt_idx;
                    end
                end
                CALC: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    D_VLD <= 1'b1;
                    D_OUT <= acc_nxt;
                    D_CH  <= g_p0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant stage: capture the winning channel and its sample for the CALC cycle.
    always_ff @(posedge CLK) begin
        if (state == IDLE && req_any) begin
            g_p0 <= gnt_idx;
            c_p0 <= C_IN[DATA_W*gnt_idx +: DATA_W];
        end
    end

    // Update stage: a clear on the serviced channel overrides its write-back.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < 4; k++) begin
            if (RESET || CLR[k]) begin
                acc[k] <= '0;
                e[k]   <= '0;
            end else if (state == CALC && g_p0 == 2'(k)) begin
                acc[k] <= acc_nxt;
                e[k]   <= e_nxt;
            end
        end
    end

endmodule

// File: tb/tb_lf_share_ctrl.sv
// Scoreboard bench for lf_share_ctrl: a transaction-level model predicts grants and results.
module tb_lf_share_ctrl;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  REQ;
    logic [31:0] C_IN;
    logic [3:0]  CLR;
    logic [3:0]  ACK;
    logic [11:0] D_OUT;
    logic [1:0]  D_CH;
    logic        D_VLD;
    logic        BUSY;

    always #5 CLK = ~CLK;

    lf_share_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .REQ   (REQ),
        .C_IN  (C_IN),
        .CLR   (CLR),
        .ACK   (ACK),
        .D_OUT (D_OUT),
        .D_CH  (D_CH),
        .D_VLD (D_VLD),
        .BUSY  (BUSY)
    );

    typedef struct {
        int cyc;
        int ch;
        int val;
    } exp_t;

    exp_t ack_q[$];
    exp_t dat_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    int m_acc[4];
    int m_e[4];
    int m_last = 3;
    bit m_busy = 1'b0;
    int m_g = 0;
    int m_c = 0;
    int hold_out = 0;
    int hold_ch = 0;

    function automatic int to_s12(input int v);
        return (v >= 2048) ? v - 4096 : v;
    endfunction

    // Reference model: plain integer arithmetic modulo 4096, one event per clock edge.
    always @(posedge CLK) begin : model
        exp_t x;
        int   nv;
        int   ne;
        bit   found;
        cyc = cyc + 1;
        if (RESET) begin
            m_last   = 3;
            m_busy   = 1'b0;
            hold_out = 0;
            hold_ch  = 0;
            for (int k = 0; k < 4; k++) begin
                m_acc[k] = 0;
                m_e[k]   = 0;
            end
        end else begin
            if (m_busy) begin
                nv = (2 * m_c + m_acc[m_g] - m_e[m_g]) & 4095;
                ne = (to_s12(m_acc[m_g]) >>> 4) & 4095;
                m_acc[m_g] = nv;
                m_e[m_g]   = ne;
                x.cyc = cyc;
                x.ch  = m_g;
                x.val = nv;
                dat_q.push_back(x);
                hold_out = nv;
                hold_ch  = m_g;
                m_busy   = 1'b0;
            end else if (REQ != 4'b0) begin
                found = 1'b0;
                for (int i = 1; i <= 4; i++) begin
                    if (!found && REQ[(m_last + i) % 4]) begin
                        found = 1'b1;
                        m_g   = (m_last + i) % 4;
                    end
                end
                m_c = int'(C_IN[8*m_g +: 8]);
                if (m_c >= 128) m_c = m_c - 256;
                x.cyc = cyc;
                x.ch  = m_g;
                x.val = 1 << m_g;
                ack_q.push_back(x);
                m_last = m_g;
                m_busy = 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                if (CLR[k]) begin
                    m_acc[k] = 0;
                    m_e[k]   = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin : monitor
        exp_t x;
        if (mon_en) begin
            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                x = ack_q.pop_front();
                tests++;
                fails++;
                $display("FAIL ack_missing: got 0x0 required 0x%0h (cycle %0d)", x.val, x.cyc);
            end
            while (dat_q.size() > 0 && dat_q[0].cyc < cyc) begin
                x = dat_q.pop_front();
                tests++;
                fails++;
                $display("FAIL dvld_missing: got no D_VLD required ch %0d 0x%0h (cycle %0d)", x.ch, x.val, x.cyc);
            end
            if (ACK !== 4'b0) begin
                tests++;
                if (ack_q.size() == 0) begin
                    fails++;
                    $display("FAIL ack_extra: got 0x%0h required 0x0 (cycle %0d)", ACK, cyc);
                end else begin
                    x = ack_q.pop_front();
                    if (ACK !== 4'(x.val)) begin
                        fails++;
                        $display("FAIL ack_value: got 0x%0h required 0x%0h (cycle %0d)", ACK, x.val, cyc);
                    end
                end
            end
            if (D_VLD !== 1'b0) begin
                tests++;
                if (dat_q.size() == 0) begin
                    fails++;
                    $display("FAIL dvld_extra: got D_VLD=%b required 0 (cycle %0d)", D_VLD, cyc);
                end else begin
                    x = dat_q.pop_front();
                    if (D_OUT !== 12'(x.val) || D_CH !== 2'(x.ch)) begin
                        fails++;
                        $display("FAIL dout_model: got ch %0d 0x%0h required ch %0d 0x%0h (cycle %0d)",
                                 D_CH, D_OUT, x.ch, x.val, cyc);
                    end
                end
            end else begin
                tests++;
                if (D_OUT !== 12'(hold_out) || D_CH !== 2'(hold_ch)) begin
                    fails++;
                    $display("FAIL dout_hold: got ch %0d 0x%0h required ch %0d 0x%0h (cycle %0d)",
                             D_CH, D_OUT, hold_ch, hold_out, cyc);
                end
            end
            tests++;
            if (BUSY !== m_busy) begin
                fails++;
                $display("FAIL busy: got %b required %b (cycle %0d)", BUSY, m_busy, cyc);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        REQ   = '0;
        CLR   = '0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // One request on channel k; exp < 0 leaves the value check to the scoreboard.
    task automatic grant(input int k, input int c, input int exp, input bit clr_calc);
        int n;
        @(negedge CLK);
        REQ = '0;
        REQ[k] = 1'b1;
        C_IN[8*k +: 8] = 8'(c);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (ACK[k] !== 1'b1 && n < 20);
        check("ack_seen", int'(ACK[k] === 1'b1), 1);
        REQ[k] = 1'b0;
        if (clr_calc) CLR[k] = 1'b1;
        @(negedge CLK);
        CLR = '0;
        check("dvld", int'(D_VLD === 1'b1), 1);
        check("dch", int'(D_CH), k);
        if (exp >= 0) check("dout", int'(D_OUT), exp);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        int exp_rr[5];
        int seq[5];
        int scyc[5];
        int nseen;
        exp_rr = '{1, 2, 4, 8, 1};
        seq    = '{0, 0, 0, 0, 0};
        scyc   = '{0, 0, 0, 0, 0};
        RESET = 1'b1;
        REQ   = '0;
        C_IN  = '0;
        CLR   = '0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_ack", int'(ACK), 0);
        check("rst_dvld", int'(D_VLD), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_dout", int'(D_OUT), 0);
        check("rst_dch", int'(D_CH), 0);
        mon_en = 1'b1;
        RESET  = 1'b0;

        grant(0, 8'h10, 12'h020, 1'b0);
        grant(0, 8'h10, 12'h040, 1'b0);
        grant(0, 8'h10, 12'h05E, 1'b0);

        do_reset();
        grant(2, 8'h80, 12'hF00, 1'b0);
        grant(2, 8'h80, 12'hE00, 1'b0);
        grant(2, 8'h00, 12'hE10, 1'b0);

        do_reset();
        @(negedge CLK);
        REQ   = 4'b1111;
        nseen = 0;
        for (int i = 0; i < 14 && nseen < 5; i++) begin
            @(negedge CLK);
            if (ACK !== 4'b0) begin
                seq[nseen]  = int'(ACK);
                scyc[nseen] = cyc;
                nseen++;
            end
        end
        REQ = '0;
        check("rr_count", nseen, 5);
        for (int i = 0; i < 5; i++) check("rr_order", seq[i], exp_rr[i]);
        for (int i = 1; i < 5; i++) check("rr_spacing", scyc[i] - scyc[i-1], 2);
        repeat (3) @(negedge CLK);

        do_reset();
        grant(0, 8'h10, 12'h020, 1'b0);
        grant(3, 8'h7F, 12'h0FE, 1'b0);
        grant(0, 8'h10, 12'h040, 1'b0);
        grant(3, 8'h7F, 12'h1FC, 1'b0);
        grant(3, 8'h7F, 12'h2EB, 1'b1);
        grant(3, 8'h7F, 12'h0FE, 1'b0);
        grant(0, 8'h10, 12'h05E, 1'b0);

        do_reset();
        @(negedge CLK);
        REQ = 4'b1111;
        @(negedge CLK);
        check("mid_busy", int'(BUSY), 1);
        REQ   = '0;
        RESET = 1'b1;
        @(negedge CLK);
        check("mid_dvld", int'(D_VLD), 0);
        check("mid_ack", int'(ACK), 0);
        check("mid_busy0", int'(BUSY), 0);
        check("mid_dout", int'(D_OUT), 0);
        RESET = 1'b0;
        @(negedge CLK);
        REQ = 4'b1111;
        @(negedge CLK);
        check("mid_first_grant", int'(ACK), 1);
        REQ = '0;
        repeat (3) @(negedge CLK);

        do_reset();
        for (int i = 0; i < 40; i++) grant(1, 8'h7F, -1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            REQ   = 4'($urandom);
            C_IN  = $urandom;
            CLR   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            RESET = ($urandom_range(0, 299) == 0);
        end
        @(negedge CLK);
        REQ   = '0;
        CLR   = '0;
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        check("ack_q_drained", ack_q.size(), 0);
        check("dat_q_drained", dat_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lf_share_ctrl.md
LF_SHARE_CTRL -- requirements
Module: lf_share_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all logic on rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port REQ, input, 4 bits: per-channel request; REQ[k] is held high until ACK[k].
REQ-004 SHALL have port C_IN, input, 32 bits: per-channel phase error, two's complement; channel k uses bits [8k+7:8k].
REQ-005 SHALL have port CLR, input, 4 bits: per-channel filter state clear, level-sensitive.
REQ-006 SHALL have port ACK, output, 4 bits: one-hot, one-cycle grant pulse.
REQ-007 SHALL have port D_OUT, output, 12 bits: updated filter accumulator of the serviced channel.
REQ-008 SHALL have port D_CH, output, 2 bits: channel index of D_OUT.
REQ-009 SHALL have port D_VLD, output, 1 bit: one-cycle strobe qualifying D_OUT and D_CH.
REQ-010 SHALL have port BUSY, output, 1 bit: high while the FSM is in CALC.

Function
REQ-011 SHALL time-share one loop-filter datapath among 4 channels; per-channel state is 12-bit ACC[k] and 12-bit E[k].
REQ-012 SHALL implement a 2-state FSM with states IDLE and CALC; all outputs are registered.
REQ-013 IDLE: if any REQ bit is high in cycle n, the block SHALL at edge n+1 enter CALC, pulse ACK[g], and latch g and C_IN[8g+7:8g].
REQ-014 IDLE with REQ==0 SHALL remain IDLE with ACK==0.
REQ-015 Arbitration SHALL be round-robin: search order LAST+1, LAST+2, LAST+3, LAST+4 (mod 4), where LAST is the last granted channel; LAST is updated on grant.
REQ-016 CALC: at edge n+2 the block SHALL update channel g and return to IDLE.
- ACC[g] <= {C[7],C[7],C[7],C,1'b0} + ACC[g] - E[g].
- E[g] <= old ACC[g] arithmetic-shifted right by 4, as {4{ACC[11]},ACC[11:4]}.
REQ-017 At the same edge n+2 the block SHALL set D_OUT to the new ACC[g], D_CH to g, and D_VLD to 1 for one cycle.
REQ-018 Arithmetic SHALL wrap modulo 2^12, with no saturation and no overflow flag.
REQ-019 REQ is sampled only in IDLE; REQ[k] dropped before ACK[k] SHALL be lost silently.
REQ-020 REQ[k] still high in the cycle after ACK[k] SHALL count as a new request. Maximum throughput is one grant per 2 cycles.
REQ-021 CLR[k] high SHALL zero ACC[k] and E[k] at the next edge.
REQ-022 If CLR[g] coincides with the CALC update of channel g, CLR SHALL win and state becomes zero. D_OUT still reports the computed value with D_VLD=1.
REQ-023 CLR SHALL NOT affect arbitration, ACK, or other channels.
REQ-024 Updates of one channel SHALL NOT modify the state of any other channel.
REQ-025 D_OUT and D_CH SHALL hold their last values when D_VLD=0.

Reset
REQ-026 RESET high at an edge SHALL force the following, overriding all other activity including an in-progress CALC:
- FSM to IDLE.
- ACC[0..3], E[0..3], D_OUT, D_CH, ACK, D_VLD, BUSY to 0.
- LAST to 3, so channel 0 has first priority.
REQ-027 A CALC interrupted by RESET SHALL produce no D_VLD, and its sample SHALL be discarded.

Verification
REQ-028 Single channel: REQ[0] with C=0x10 for three grants -> D_OUT = 0x020, 0x040, 0x05E; D_CH=0; ACK and D_VLD spaced 2 cycles apart.
REQ-029 Negative input: after reset, one grant on channel 2 with C=0x80 -> D_OUT=0xF00, D_CH=2; second C=0x80 -> D_OUT=0xE00 (E=0x000 at that update; E becomes 0xFF0).
REQ-030 Round-robin: REQ=4'b1111 held -> ACK sequence 0001, 0010, 0100, 1000, 0001, one grant every 2 cycles; BUSY alternates 1/0.
REQ-031 Isolation and clear: interleave channels 0 and 3 with C=0x10 and 0x7F, then assert CLR[3] in the same cycle as a channel-3 CALC -> that D_OUT is reported, but the next channel-3 result equals a from-zero first sample (0x0FE). Channel 0 continues its own sequence unaffected.
REQ-032 Reset mid-operation: RESET asserted in the CALC cycle -> no D_VLD, all outputs 0. The next REQ=4'b1111 is granted to channel 0 first.
REQ-033 Wrap: channel 1 with C=0x7F repeated 40 times -> D_OUT matches a 12-bit modulo reference model every sample, with no saturation.
